// File: rtl/plic_gateway_array.sv
// PLIC gateway array: per-source edge/level requests become a single-outstanding ip bit; src->ip takes 2 edges
// (3 with PLIC_GW_SYNC_EN, which adds a synchroniser flop); no backpressure, claim/complete strobes always accepted.
module plic_gateway_array #(
   parameter int SOURCES = 8,
   parameter int CNT_W   = 4,
   parameter int ID_W    = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SOURCES-1:0] src,
   input  logic [SOURCES-1:0] src_pol,
   input  logic [SOURCES-1:0] edge_lvl,
   input  logic               claim_vld,
   input  logic [ID_W-1:0]    claim_id,
   input  logic               complete_vld,
   input  logic [ID_W-1:0]    complete_id,
   input  logic [SOURCES-1:0] ovf_clr,
   output logic [SOURCES-1:0] ip,
   output logic [SOURCES-1:0] ovf
);

   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, CLAIMED = 2'd2} gw_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SOURCES-1:0] s;
   logic [SOURCES-1:0] s_in;
   logic [SOURCES-1:0] s_r;
   logic [SOURCES-1:0] s_dly;
   logic [SOURCES-1:0] edge_evt;

   assign s = src ^ src_pol;

`ifdef PLIC_GW_SYNC_EN
   logic [SOURCES-1:0] s_meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_meta <= '0;
      else        s_meta <= s;
   end

   assign s_in = s_meta;
`else
   assign s_in = s;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r   <= '0;
         s_dly <= '0;
      end else begin
         s_r   <= s_in;
         s_dly <= s_r;
      end
   end

   assign edge_evt = s_r & ~s_dly;

   for (genvar i = 0; i < SOURCES; i++) begin : g_ch
      localparam logic [ID_W-1:0] MY_ID = ID_W'(i + 1);

      gw_state_t        state;
      gw_state_t        state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             take;
      logic             dec;
      logic             ovf_set;
      logic             claim_hit;
      logic             complete_hit;
      logic             ip_q;
      logic             ovf_q;

      assign claim_hit    = claim_vld && (claim_id == MY_ID);
      assign complete_hit = complete_vld && (complete_id == MY_ID);

      always_comb begin
         state_nxt = state;
         take      = 1'b0;
         case (state)
            IDLE: begin
               take = edge_lvl[i] ? ((cnt != '0) || edge_evt[i]) : s_r[i];
               if (take) state_nxt = PEND;
            end
            PEND:    if (claim_hit)    state_nxt = CLAIMED;
            CLAIMED: if (complete_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end

      // The edge that launches an IDLE->PEND is consumed in the same cycle, so evt+dec nets to zero.
      assign dec = take && edge_lvl[i];

      always_comb begin
         cnt_nxt = cnt;
         ovf_set = 1'b0;
         if (!edge_lvl[i]) begin
            cnt_nxt = '0;
         end else if (edge_evt[i] && !dec) begin
            if (cnt == CNT_MAX) ovf_set = 1'b1;
            else                cnt_nxt = cnt + 1'b1;
         end else if (dec && !edge_evt[i]) begin
            cnt_nxt = cnt - 1'b1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ip_q  <= 1'b0;
            ovf_q <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ip_q  <= (state_nxt == PEND);
            if (ovf_set)         ovf_q <= 1'b1;
            else if (ovf_clr[i]) ovf_q <= 1'b0;
         end
      end

      assign ip[i]  = ip_q;
      assign ovf[i] = ovf_q;
   end

endmodule

// File: tb/tb_plic_gateway_array.sv
// Self-checking bench for plic_gateway_array: directed scenarios with literal expectations plus a randomized run,
// every cycle compared against a behavioural per-source model (pending-edge count, claim state, sticky overflow).
module tb_plic_gateway_array;
   localparam int SRC  = 8;
   localparam int CW   = 2;
   localparam int IW   = 10;
   localparam int CMAX = (1 << CW) - 1;
`ifdef PLIC_GW_SYNC_EN
   localparam int LAT  = 3;
   localparam bit SYNC = 1'b1;
`else
   localparam int LAT  = 2;
   localparam bit SYNC = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [SRC-1:0] src = '0;
   logic [SRC-1:0] src_pol = '0;
   logic [SRC-1:0] edge_lvl = '1;
   logic           claim_vld = 1'b0;
   logic [IW-1:0]  claim_id = '0;
   logic           complete_vld = 1'b0;
   logic [IW-1:0]  complete_id = '0;
   logic [SRC-1:0] ovf_clr = '0;
   logic [SRC-1:0] ip;
   logic [SRC-1:0] ovf;

   always #5 clk = ~clk;

   plic_gateway_array #(.SOURCES(SRC), .CNT_W(CW), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .src(src), .src_pol(src_pol), .edge_lvl(edge_lvl),
      .claim_vld(claim_vld), .claim_id(claim_id), .complete_vld(complete_vld),
      .complete_id(complete_id), .ovf_clr(ovf_clr), .ip(ip), .ovf(ovf)
   );

   int checks = 0;
   int errors = 0;

   // Model: delay line of polarity-corrected samples, pending-edge count, 0=idle 1=pending 2=claimed.
   bit m_meta[SRC];
   bit m_sr[SRC];
   bit m_sdly[SRC];
   int m_cnt[SRC];
   int m_st[SRC];
   bit m_ovf[SRC];

   task automatic check(input string name, input logic [SRC-1:0] got, input logic [SRC-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [SRC-1:0] m_ip_v();
      logic [SRC-1:0] r;
      for (int i = 0; i < SRC; i++) r[i] = (m_st[i] == 1);
      return r;
   endfunction

   function automatic logic [SRC-1:0] m_ovf_v();
      logic [SRC-1:0] r;
      for (int i = 0; i < SRC; i++) r[i] = m_ovf[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SRC; i++) begin
         m_meta[i] = 0; m_sr[i] = 0; m_sdly[i] = 0;
         m_cnt[i] = 0; m_st[i] = 0; m_ovf[i] = 0;
      end
   endtask

   task automatic model_step();
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < SRC; i++) begin
         bit s_now, evt, take, dec, hit_c, hit_d;
         int n;
         s_now = src[i] ^ src_pol[i];
         evt   = m_sr[i] && !m_sdly[i];
         hit_c = claim_vld && (claim_id == IW'(i + 1));
         hit_d = complete_vld && (complete_id == IW'(i + 1));
         take  = (m_st[i] == 0) && (edge_lvl[i] ? (m_cnt[i] > 0 || evt) : m_sr[i]);
         dec   = take && edge_lvl[i];
         if (!edge_lvl[i]) begin
            m_cnt[i] = 0;
         end else begin
            n = m_cnt[i] + (evt ? 1 : 0) - (dec ? 1 : 0);
            if (n > CMAX) begin
               n = CMAX;
               m_ovf[i] = 1;
            end else if (ovf_clr[i]) begin
               m_ovf[i] = 0;
            end
            m_cnt[i] = n;
         end
         if (!edge_lvl[i] && ovf_clr[i]) m_ovf[i] = 0;
         if (m_st[i] == 0 && take)       m_st[i] = 1;
         else if (m_st[i] == 1 && hit_c) m_st[i] = 2;
         else if (m_st[i] == 2 && hit_d) m_st[i] = 0;
         m_sdly[i] = m_sr[i];
         m_sr[i]   = SYNC ? m_meta[i] : s_now;
         m_meta[i] = s_now;
      end
   endtask

   // Single compare point: every cycle, both outputs against the model.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("ip_vs_model", ip, m_ip_v());
      check("ovf_vs_model", ovf, m_ovf_v());
   endtask

   task automatic claim(input int id);
      claim_vld = 1'b1; claim_id = IW'(id);
      tick();
      claim_vld = 1'b0; claim_id = '0;
   endtask

   task automatic complete(input int id);
      complete_vld = 1'b1; complete_id = IW'(id);
      tick();
      complete_vld = 1'b0; complete_id = '0;
   endtask

   task automatic pulse(input logic [SRC-1:0] m);
      src = src | m;
      tick();
      src = src & ~m;
      tick();
   endtask

   task automatic raise_and_wait(input logic [SRC-1:0] m);
      src = src | m;
      tick();
      src = src & ~m;
      repeat (LAT - 1) tick();
   endtask

   initial begin
      model_reset();
      repeat (2) tick();
      check("reset_ip", ip, '0);
      check("reset_ovf", ovf, '0);
      rst_n = 1'b1;
      tick();

      // Single edge on ID 3: latency, claim, complete.
      src = 8'h04;
      tick();
      src = '0;
      for (int n = 1; n < LAT; n++) begin
         check("t1_not_yet", ip, '0);
         tick();
      end
      check("t1_ip_rise", ip, 8'h04);
      claim(3);
      check("t1_claimed", ip, '0);
      complete(3);
      check("t1_completed", ip, '0);
      repeat (3) tick();
      check("t1_idle", ip, '0);

      // Overflow on ID 1: five edges while claimed saturate at 3.
      raise_and_wait(8'h01);
      check("t2_pend", ip, 8'h01);
      claim(1);
      check("t2_claimed", ip, '0);
      for (int p = 0; p < 5; p++) pulse(8'h01);
      repeat (2) tick();
      check("t2_ovf", ovf, 8'h01);
      check("t2_ip_hold", ip, '0);
      complete(1);
      for (int n = 0; n < 3; n++) begin
         tick();
         check("t2_reissue", ip, 8'h01);
         claim(1);
         complete(1);
      end
      repeat (4) tick();
      check("t2_drained", ip, '0);
      ovf_clr = 8'h01;
      tick();
      ovf_clr = '0;
      check("t2_ovf_clr", ovf, '0);

      // Level mode, active-low, on ID 2.
      edge_lvl = 8'hFD;
      src_pol  = 8'h02;
      repeat (LAT) tick();
      check("t3_lvl_pend", ip, 8'h02);
      claim(2);
      check("t3_claimed", ip, '0);
      complete(2);
      check("t3_after_cmp", ip, '0);
      tick();
      check("t3_repend", ip, 8'h02);
      src = 8'h02;
      claim(2);
      repeat (2) tick();
      complete(2);
      repeat (2) tick();
      check("t3_released", ip, '0);
      src = '0; src_pol = '0; edge_lvl = '1;
      repeat (3) tick();

      // Ignored claims, then simultaneous claim 1 / complete 2.
      claim(0);
      check("t4_id0", ip, '0);
      claim(SRC + 1);
      check("t4_id_hi", ip, '0);
      claim(4);
      check("t4_idle_claim", ip, '0);
      raise_and_wait(8'h03);
      check("t4_two_pend", ip, 8'h03);
      claim(2);
      check("t4_one_claimed", ip, 8'h01);
      claim_vld = 1'b1; claim_id = IW'(1);
      complete_vld = 1'b1; complete_id = IW'(2);
      tick();
      claim_vld = 1'b0; complete_vld = 1'b0;
      check("t4_both_applied", ip, '0);
      complete(1);
      raise_and_wait(8'h02);
      check("t4_ch2_idle_again", ip, 8'h02);
      claim(2);
      complete(2);

      // Async reset mid-claim with counted edges and a set overflow.
      raise_and_wait(8'h11);
      check("t5_pend", ip, 8'h11);
      claim(1);
      claim(5);
      for (int p = 0; p < 4; p++) pulse(p < 2 ? 8'h11 : 8'h10);
      repeat (2) tick();
      check("t5_ovf", ovf, 8'h10);
      raise_and_wait(8'h04);
      check("t5_pend3", ip, 8'h04);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("t5_rst_ip", ip, '0);
      check("t5_rst_ovf", ovf, '0);
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("t5_no_ip_after_rst", ip, '0);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         src = src ^ (SRC'($urandom_range(0, 255)) & SRC'($urandom_range(0, 255)) & SRC'($urandom_range(0, 255)));
         if ($urandom_range(0, 199) == 0) src_pol = SRC'($urandom_range(0, 255));
         if ($urandom_range(0, 299) == 0) edge_lvl = SRC'($urandom_range(0, 255));
         claim_vld    = ($urandom_range(0, 1) == 0);
         claim_id     = IW'($urandom_range(0, SRC + 2));
         complete_vld = ($urandom_range(0, 1) == 0);
         complete_id  = IW'($urandom_range(0, SRC + 2));
         ovf_clr      = ($urandom_range(0, 15) == 0) ? SRC'($urandom_range(0, 255)) : '0;
         tick();
      end
      claim_vld = 1'b0; complete_vld = 1'b0; ovf_clr = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/plic_gateway_array.md
Name: plic_gateway_array

Overview:
- Parametrised array of PLIC interrupt gateways, one per external source, sitting between raw interrupt lines and the PLIC priority/claim logic.
- Each channel converts edge or level requests into a single-outstanding interrupt-pending bit (ip).
- Each channel has a configurable-depth edge counter, per-source polarity and an overflow flag.
- Claim and complete arrive as ID-addressed strobes from the PLIC claim/complete register.

Parameters:
SOURCES, 8, number of gateway channels (1..1023); source IDs are 1..SOURCES, ID 0 is reserved.
CNT_W, 4, pending-edge counter width; counter saturates at 2^CNT_W-1.
ID_W, 10, width of claim/complete ID buses; must satisfy 2^ID_W > SOURCES.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
src  input  SOURCES  raw interrupt request lines.
src_pol  input  SOURCES  per-source polarity; 1 = active-low source (inverted before use).
edge_lvl  input  SOURCES  per-source mode; 1 = edge, 0 = level.
claim_vld  input  1  claim strobe, one cycle.
claim_id  input  ID_W  ID being claimed.
complete_vld  input  1  completion strobe, one cycle.
complete_id  input  ID_W  ID being completed.
ovf_clr  input  SOURCES  per-source clear for the overflow flag.
ip  output  SOURCES  interrupt pending to PLIC, bit i = ID i+1.
ovf  output  SOURCES  sticky flag: edge lost because the counter was saturated.

Behaviour:
- Reset (asynchronous) clears all of the following: s_r, s_dly, counters, states, ip, ovf.
- Per channel: s = src ^ src_pol.
- Registers: s_r <= s and s_dly <= s_r. Combinational edge_evt = s_r & ~s_dly.
- Counter next value, using dec = (IDLE->PEND transition taken this cycle):
  - edge_evt & ~dec: cnt+1, saturating at max.
  - dec & ~edge_evt: cnt-1.
  - both or neither: cnt unchanged.
- edge_evt with cnt == max and no dec: cnt stays at max, ovf set.
- ovf set has priority over ovf_clr in the same cycle.
- When edge_lvl = 0, cnt is forced to 0 every cycle. Switching mode does not alter the state.
- State machine per channel has three states: IDLE, PEND, CLAIMED. ip = (state == PEND).
- IDLE -> PEND when either condition holds:
  - edge mode and (cnt != 0 or edge_evt);
  - level mode and s_r = 1.
- The counter decrement for a taken edge-mode IDLE->PEND transition happens on the same clock edge. A simultaneous edge_evt on an empty counter therefore leaves cnt at 0.
- PEND -> CLAIMED on claim_vld with claim_id == i+1.
- CLAIMED -> IDLE on complete_vld with complete_id == i+1.
- Claim to a channel not in PEND is ignored.
- Complete to a channel not in CLAIMED is ignored.
- IDs of 0 or greater than SOURCES are ignored.
- Claim and complete in the same cycle to different IDs are both applied. To the same ID, only the one matching the current state applies.
- Level source deasserting while in PEND or CLAIMED: no state change; ip stays until claimed.
- After completion, a level source still asserted re-enters PEND on the next edge.
- Latency: source asserted before clock edge k gives ip = 1 after edge k+1 (two edges).
- Edges arriving while PEND or CLAIMED are counted. Each counted edge produces one further ip after completion.
- Channels are fully independent. There is no combinational path from claim or complete to ip.

Optional Feature:
PLIC_GW_SYNC_EN.
- Defined: inserts one additional metastability flop on s ahead of s_r (two-flop synchroniser for asynchronous sources). Assert latency becomes three edges. The extra flop is cleared on reset.
- Undefined: s feeds s_r directly; src must be synchronous to clk.

Test Plan:
- Edge, ID 3: single pulse on src[2] at edge k -> ip[2] = 1 after k+1. Claim ID 3 -> ip[2] = 0. Complete ID 3 -> stays 0, cnt = 0.
- Edge, CNT_W = 2: 5 pulses while CLAIMED -> cnt = 3, ovf[0] = 1. Complete -> exactly 3 further ip/claim/complete cycles, then idle.
- Level, src_pol = 1: hold src = 0 -> ip = 1. Claim, complete while still low -> ip = 1 again one edge after complete. Raise src before complete -> ip stays 0.
- Claim ID 0, ID SOURCES+1, and claim of an IDLE channel -> no ip or state change anywhere. Simultaneous claim ID 1 and complete ID 2 -> both applied.
- Assert rst_n = 0 mid-CLAIMED with cnt = 2 -> ip, ovf, cnt immediately 0. After release, no ip without a new edge.
- With PLIC_GW_SYNC_EN: single edge -> ip rises after the third edge. Without: after the second edge.
